pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Pipeline hazard controller for the 5-stage RISC-V core. It sits beside the operand-forwarding unit and sequences every stall and flush the forwarding paths cannot cover: load-use bubbles, taken-branch flushes, and multi-cycle MUL/DIV occupancy of EX. It owns the MUL/DIV busy state machine and exports per-stage write-enable, flush and start controls, plus saturating stall and flush statistics counters.

## Interface

- MD_LATENCY, 4, MUL/DIV unit latency in cycles; legal range 2..16
- clk_i  input  1  core clock; all state updates on rising edge
- rst_n_i  input  1  reset, synchronous, active-low
- ID_Rs1_i  input  5  rs1 of instruction in ID
- ID_Rs2_i  input  5  rs2 of instruction in ID
- ID_UsesRs1_i  input  1  ID instruction reads rs1
- ID_UsesRs2_i  input  1  ID instruction reads rs2
- EX_MemRead_i  input  1  EX instruction is a load
- EX_Rd_i  input  5  rd of EX instruction
- EX_MulDiv_i  input  1  EX instruction is MUL/DIV
- EX_BranchTaken_i  input  1  EX branch/jump resolved taken
- PC_Write_o  output  1  PC update enable
- IFID_Write_o  output  1  IF/ID register enable
- IDEX_Write_o  output  1  ID/EX register enable
- IFID_Flush_o  output  1  clear IF/ID to NOP
- IDEX_Flush_o  output  1  load NOP into ID/EX
- EXMEM_Flush_o  output  1  load NOP into EX/MEM
- MD_Start_o  output  1  one-cycle start pulse to MUL/DIV unit
- MD_Busy_o  output  1  MUL/DIV sequence in progress (RUN state)
- MD_ResultValid_o  output  1  MUL/DIV result may be captured this cycle
- StallCycles_o  output  32  cycles with PC_Write_o=0
- FlushCount_o  output  32  cycles with IFID_Flush_o=1

## Operation

- States: IDLE, RUN, DONE; 4-bit down-counter cnt.
- IDLE: EX_MulDiv_i=1 -> MD_Start_o=1, md_stall=1, cnt<=MD_LATENCY-2, go RUN.
- RUN: md_stall=1; cnt==0 -> DONE, else cnt<=cnt-1. RUN lasts exactly MD_LATENCY-1 cycles.
- DONE: md_stall=0, MD_ResultValid_o=1; EX_MulDiv_i ignored (same instruction leaving EX); always -> IDLE.
- load_use = EX_MemRead_i & EX_Rd_i!=0 & ((ID_UsesRs1_i & EX_Rd_i==ID_Rs1_i) | (ID_UsesRs2_i & EX_Rd_i==ID_Rs2_i)).
- Priority, highest first:
  - md_stall: PC_Write_o=IFID_Write_o=IDEX_Write_o=0, EXMEM_Flush_o=1, all other flushes 0.
  - EX_BranchTaken_i: IFID_Flush_o=IDEX_Flush_o=1, all writes 1; load_use ignored.
  - load_use: PC_Write_o=IFID_Write_o=0, IDEX_Write_o=1, IDEX_Flush_o=1.
  - none: all writes 1, all flushes 0.
- Control outputs are combinational from state and inputs. Counters are registered.
- StallCycles_o increments when PC_Write_o=0. FlushCount_o increments when IFID_Flush_o=1. Both saturate at 0xFFFFFFFF.

## Timing

- Reset (rst_n_i=0 at an edge): state=IDLE, cnt=0, counters=0. Outputs during/after reset: writes=1, flushes=0, MD_Start_o=0, MD_Busy_o=0, MD_ResultValid_o=0.
- Reset mid-RUN aborts the sequence; next cycle IDLE, no ResultValid.
- MUL/DIV in EX: stalled for MD_LATENCY cycles (entry + RUN), then 1 DONE cycle. EX occupancy = MD_LATENCY+1 cycles.
- Back-to-back MUL/DIV: second enters EX after DONE; detected in IDLE, no gap cycle lost.
- Load-use: exactly 1 bubble cycle; the next cycle EX holds the bubble, so load_use clears.
- Branch resolves in EX: 2 flushed slots, zero-cycle decision latency.
- MD_LATENCY=2: RUN lasts 1 cycle (cnt loaded 0).

## Test plan

- Reset: hold rst_n_i=0 for 3 cycles with EX_MulDiv_i=1 -> MD_Start_o=0, PC_Write_o=1, counters 0 after release.
- MUL, MD_LATENCY=4: EX_MulDiv_i=1 at cycle t -> MD_Start_o=1 only at t, PC_Write_o=0 on t..t+3, MD_ResultValid_o=1 at t+4, StallCycles_o=4.
- Load-use: EX_MemRead_i=1, EX_Rd_i=5, ID_Rs2_i=5, ID_UsesRs2_i=1 -> one cycle PC_Write_o=0, IDEX_Flush_o=1. With EX_Rd_i=0 -> no stall.
- Branch with load-use in the same cycle -> IFID_Flush_o=IDEX_Flush_o=1, PC_Write_o=1, FlushCount_o +1.
- Reset asserted during RUN cnt=1 -> IDLE next cycle, MD_Busy_o=0, no ResultValid pulse. Two consecutive MULs -> two Start pulses 5 cycles apart.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencer for the 5-stage core: load-use bubbles, taken-branch flushes
// and MUL/DIV occupancy of EX, plus saturating stall/flush statistics.
module pipeline_hazard_ctrl #(
  parameter int unsigned MD_LATENCY = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [4:0]  ID_Rs1_i,
  input  logic [4:0]  ID_Rs2_i,
  input  logic        ID_UsesRs1_i,
  input  logic        ID_UsesRs2_i,
  input  logic        EX_MemRead_i,
  input  logic [4:0]  EX_Rd_i,
  input  logic        EX_MulDiv_i,
  input  logic        EX_BranchTaken_i,
  output logic        PC_Write_o,
  output logic        IFID_Write_o,
  output logic        IDEX_Write_o,
  output logic        IFID_Flush_o,
  output logic        IDEX_Flush_o,
  output logic        EXMEM_Flush_o,
  output logic        MD_Start_o,
  output logic        MD_Busy_o,
  output logic        MD_ResultValid_o,
  output logic [31:0] StallCycles_o,
  output logic [31:0] FlushCount_o
);

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  localparam logic [3:0] CNT_INIT = 4'(MD_LATENCY - 2);

  md_state_e   state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;
  logic        md_start;
  logic        md_stall;
  logic        load_use;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= MD_IDLE;
      cnt_q       <= 4'd0;
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // MUL/DIV handshake: MD_Start_o is a single-cycle request with no ready
  // back-pressure; the result is valid for exactly the one DONE cycle.
  // EX is frozen from the start cycle through the last RUN cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    md_start = 1'b0;
    md_stall = 1'b0;
    case (state_q)
      MD_IDLE: begin
        if (EX_MulDiv_i) begin
          md_start = 1'b1;
          md_stall = 1'b1;
          cnt_d    = CNT_INIT;
          state_d  = MD_RUN;
        end
      end
      MD_RUN: begin
        md_stall = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d = MD_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      MD_DONE: begin
        state_d = MD_IDLE;
      end
      default: begin
        state_d = MD_IDLE;
      end
    endcase
  end

  assign load_use = EX_MemRead_i && (EX_Rd_i != 5'd0) &&
                    ((ID_UsesRs1_i && (EX_Rd_i == ID_Rs1_i)) ||
                     (ID_UsesRs2_i && (EX_Rd_i == ID_Rs2_i)));

  // Reset forces the free-running pipeline view regardless of inputs.
  always_comb begin
    PC_Write_o    = 1'b1;
    IFID_Write_o  = 1'b1;
    IDEX_Write_o  = 1'b1;
    IFID_Flush_o  = 1'b0;
    IDEX_Flush_o  = 1'b0;
    EXMEM_Flush_o = 1'b0;
    if (rst_n_i) begin
      if (md_stall) begin
        PC_Write_o    = 1'b0;
        IFID_Write_o  = 1'b0;
        IDEX_Write_o  = 1'b0;
        EXMEM_Flush_o = 1'b1;
      end else if (EX_BranchTaken_i) begin
        IFID_Flush_o = 1'b1;
        IDEX_Flush_o = 1'b1;
      end else if (load_use) begin
        PC_Write_o   = 1'b0;
        IFID_Write_o = 1'b0;
        IDEX_Flush_o = 1'b1;
      end
    end
  end

  assign MD_Start_o       = rst_n_i && md_start;
  assign MD_Busy_o        = rst_n_i && (state_q == MD_RUN);
  assign MD_ResultValid_o = rst_n_i && (state_q == MD_DONE);

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!PC_Write_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (IFID_Flush_o && (flush_cnt_q != 32'hFFFF_FFFF)) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  assign StallCycles_o = stall_cnt_q;
  assign FlushCount_o  = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios then random traffic,
// all checked against a cycle-age reference model and a result-timing queue.
module tb_pipeline_hazard_ctrl;

  localparam int L = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_u1, id_u2, ex_mem, ex_mul, ex_br;
  logic        pc_w, ifid_w, idex_w, ifid_f, idex_f, exmem_f;
  logic        md_start, md_busy, md_valid;
  logic [31:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MD_LATENCY(L)) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .ID_Rs1_i        (id_rs1),
    .ID_Rs2_i        (id_rs2),
    .ID_UsesRs1_i    (id_u1),
    .ID_UsesRs2_i    (id_u2),
    .EX_MemRead_i    (ex_mem),
    .EX_Rd_i         (ex_rd),
    .EX_MulDiv_i     (ex_mul),
    .EX_BranchTaken_i(ex_br),
    .PC_Write_o      (pc_w),
    .IFID_Write_o    (ifid_w),
    .IDEX_Write_o    (idex_w),
    .IFID_Flush_o    (ifid_f),
    .IDEX_Flush_o    (idex_f),
    .EXMEM_Flush_o   (exmem_f),
    .MD_Start_o      (md_start),
    .MD_Busy_o       (md_busy),
    .MD_ResultValid_o(md_valid),
    .StallCycles_o   (stall_cnt),
    .FlushCount_o    (flush_cnt)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: md_age is cycles since the MUL/DIV start (-1 = free).
  int          md_age = -1;
  logic [31:0] m_stall = 32'd0;
  logic [31:0] m_flush = 32'd0;
  int          cyc = 0;
  int          last_start = -100;
  int          prev_start = -100;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step(input logic rst, input logic mul, input logic br, input logic mem,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2);
    logic e_pc, e_ifw, e_idw, e_iff, e_idf, e_exf;
    logic e_start, e_busy, e_valid, stall, lu;
    rst_n = rst; ex_mul = mul; ex_br = br; ex_mem = mem;
    ex_rd = rd; id_rs1 = rs1; id_rs2 = rs2; id_u1 = u1; id_u2 = u2;
    @(negedge clk);
    e_start = rst && (md_age < 0) && mul;
    e_busy  = rst && (md_age >= 1) && (md_age <= L - 1);
    e_valid = rst && (md_age == L);
    stall   = e_start || e_busy;
    lu = mem && (rd != 0) && ((u1 && rd == rs1) || (u2 && rd == rs2));
    {e_pc, e_ifw, e_idw, e_iff, e_idf, e_exf} = 6'b111_000;
    if (rst) begin
      if (stall)   {e_pc, e_ifw, e_idw, e_exf} = 4'b0001;
      else if (br) {e_iff, e_idf} = 2'b11;
      else if (lu) {e_pc, e_ifw, e_idf} = 3'b001;
    end
    check("pc_write", 32'(pc_w), 32'(e_pc));
    check("ifid_write", 32'(ifid_w), 32'(e_ifw));
    check("idex_write", 32'(idex_w), 32'(e_idw));
    check("ifid_flush", 32'(ifid_f), 32'(e_iff));
    check("idex_flush", 32'(idex_f), 32'(e_idf));
    check("exmem_flush", 32'(exmem_f), 32'(e_exf));
    check("md_start", 32'(md_start), 32'(e_start));
    check("md_busy", 32'(md_busy), 32'(e_busy));
    check("stall_cnt", stall_cnt, m_stall);
    check("flush_cnt", flush_cnt, m_flush);
    // Result timing scoreboard: each start books a valid exactly L cycles later.
    if (md_valid === 1'b1) begin
      if (exp_q.size() == 0) check("valid_unexpected", 32'd1, 32'd0);
      else check("valid_cycle", 32'(cyc), exp_q.pop_front());
    end else if (e_valid) begin
      check("valid_missing", 32'(md_valid), 32'd1);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end
    if (md_start === 1'b1) begin
      prev_start = last_start;
      last_start = cyc;
    end
    if (!rst) begin
      md_age = -1; m_stall = 32'd0; m_flush = 32'd0;
      exp_q.delete();
    end else begin
      if (e_start) begin
        md_age = 1;
        exp_q.push_back(32'(cyc + L));
      end else if (md_age >= 1 && md_age < L) md_age++;
      else if (md_age == L) md_age = -1;
      if (!e_pc && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (e_iff && m_flush != 32'hFFFF_FFFF) m_flush++;
    end
    cyc++;
    @(posedge clk); #1;
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 0; ex_mul = 0; ex_br = 0; ex_mem = 0; ex_rd = 0;
    id_rs1 = 0; id_rs2 = 0; id_u1 = 0; id_u2 = 0;
    repeat (2) @(posedge clk);
    #1;

    // Reset held with a MUL/DIV in EX: no start, pipeline free-running.
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0, 0, 0, 0);
    check("rst_stall_cnt", stall_cnt, 32'd0);
    check("rst_flush_cnt", flush_cnt, 32'd0);

    // Single MUL: 4 stall cycles, result at t+4.
    for (int i = 0; i < L + 1; i++) step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("mul_stall_total", stall_cnt, 32'(L));

    // Load-use on rs2, then the bubble; then rd=x0 never stalls.
    step(1, 0, 0, 1, 5'd5, 5'd1, 5'd5, 0, 1);
    step(1, 0, 0, 0, 5'd0, 5'd1, 5'd5, 0, 1);
    step(1, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 1);

    // Branch beats load-use.
    step(1, 0, 1, 1, 5'd7, 5'd7, 5'd2, 1, 0);
    check("br_flush_cnt", flush_cnt, 32'd1);

    // Reset during RUN with cnt=1 aborts without a result.
    step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("abort_no_pending", 32'(exp_q.size()), 32'd0);
    idle_steps(L + 1);

    // Back-to-back MUL/DIV: starts L+1 cycles apart.
    for (int i = 0; i < 2 * (L + 1); i++) step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    check("b2b_gap", 32'(last_start - prev_start), 32'(L + 1));
    idle_steps(L + 1);

    // Random traffic with small register numbers so hazards hit often.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 59) != 0),
           ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 2) == 0),
           5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)));
    end
    idle_steps(2 * L + 2);
    check("final_pending", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
